// File: rtl/duck_game_pkg.sv
// Shared state encoding and default game constants for the Duck Hunt round sequencer.
package duck_game_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_INTRO     = 4'd1,
    S_LAUNCH    = 4'd2,
    S_FLY       = 4'd3,
    S_FALL      = 4'd4,
    S_ESCAPE    = 4'd5,
    S_TALLY     = 4'd6,
    S_ROUND_END = 4'd7,
    S_OVER      = 4'd8
  } state_t;

  localparam int DEF_DUCKS_PER_ROUND = 10;
  localparam int DEF_SHOTS_PER_DUCK  = 3;
  localparam int DEF_FLY_TICKS       = 480;
  localparam int DEF_PASS_HITS       = 6;
  localparam int DEF_POINTS_PER_HIT  = 500;

endpackage

// File: rtl/duck_round_sequencer_rise_detect.sv
// Rising-edge detector: registered history, rise is current level AND NOT previous level.
module rise_detect (
  input  logic Clk,
  input  logic Reset,
  input  logic i_d,
  output logic o_rise
);

  logic r_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_q <= 1'b0;
    else       r_q <= i_d;
  end

  assign o_rise = i_d & ~r_q;

endmodule

// File: rtl/duck_round_sequencer.sv
// Duck Hunt game scheduler: intro, launches, shots, escape/fall, round progression and HUD counters.
module duck_round_sequencer
  import duck_game_pkg::*;
#(
  parameter int DUCKS_PER_ROUND = DEF_DUCKS_PER_ROUND,
  parameter int SHOTS_PER_DUCK  = DEF_SHOTS_PER_DUCK,
  parameter int FLY_TICKS       = DEF_FLY_TICKS,
  parameter int PASS_HITS       = DEF_PASS_HITS,
  parameter int POINTS_PER_HIT  = DEF_POINTS_PER_HIT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Anim_Tick,
  input  logic        Start,
  input  logic        Dog_Done,
  input  logic        Trigger,
  input  logic        Hit,
  input  logic        Duck_Offscreen,
  input  logic        Duck_Landed,
  output logic        Dog_Run,
  output logic        Duck_Launch,
  output logic        Duck_Shot,
  output logic        Duck_FlyAway,
  output logic        Game_Over,
  output logic [1:0]  Shots_Left,
  output logic [3:0]  Duck_Index,
  output logic [3:0]  Hits,
  output logic [15:0] Score,
  output logic [7:0]  Round,
  output logic [3:0]  State
);

  logic w_start_rise, w_trig_rise;

  rise_detect u_start_rd (.Clk(Clk), .Reset(Reset), .i_d(Start),   .o_rise(w_start_rise));
  rise_detect u_trig_rd  (.Clk(Clk), .Reset(Reset), .i_d(Trigger), .o_rise(w_trig_rise));

  state_t      r_state, w_next;
  logic        r_dog_run, r_launch, r_shot, r_flyaway, r_over;
  logic        w_dog_run, w_launch, w_shot;
  logic [1:0]  r_shots, w_shots;
  logic [3:0]  r_idx, w_idx, r_hits, w_hits;
  logic [15:0] r_score, w_score;
  logic [7:0]  r_round, w_round;
  logic [9:0]  r_timer, w_timer;
  logic [16:0] w_sum;
  logic        w_timeout;

  assign w_sum     = {1'b0, r_score} + 17'(POINTS_PER_HIT);
  assign w_timeout = Anim_Tick && (r_timer == 10'(FLY_TICKS - 1));

  always_comb begin
    w_next    = r_state;
    w_dog_run = 1'b0;
    w_launch  = 1'b0;
    w_shot    = 1'b0;
    w_shots   = r_shots;
    w_idx     = r_idx;
    w_hits    = r_hits;
    w_score   = r_score;
    w_round   = r_round;
    w_timer   = r_timer;
    case (r_state)
      S_IDLE, S_OVER: begin
        if (w_start_rise) begin
          w_score   = 16'd0;
          w_hits    = 4'd0;
          w_idx     = 4'd0;
          w_round   = 8'd1;
          w_dog_run = 1'b1;
          w_next    = S_INTRO;
        end
      end
      S_INTRO: if (Dog_Done) w_next = S_LAUNCH;
      S_LAUNCH: begin
        w_launch = 1'b1;
        w_shots  = 2'(SHOTS_PER_DUCK);
        w_timer  = 10'd0;
        w_next   = S_FLY;
      end
      S_FLY: begin
        if (Anim_Tick) w_timer = r_timer + 10'd1;
        // Hit beats out-of-shots beats timeout, even when all land in one cycle.
        if (w_trig_rise && (r_shots != 2'd0)) begin
          w_shots = r_shots - 2'd1;
          if (Hit) begin
            w_shot  = 1'b1;
            w_hits  = r_hits + 4'd1;
            w_score = w_sum[16] ? 16'hFFFF : w_sum[15:0];
            w_next  = S_FALL;
          end else if (r_shots == 2'd1 || w_timeout) begin
            w_next = S_ESCAPE;
          end
        end else if (w_timeout) begin
          w_next = S_ESCAPE;
        end
      end
      S_FALL:   if (Duck_Landed)    w_next = S_TALLY;
      S_ESCAPE: if (Duck_Offscreen) w_next = S_TALLY;
      S_TALLY: begin
        if (r_idx == 4'(DUCKS_PER_ROUND - 1)) begin
          w_next = S_ROUND_END;
        end else begin
          w_idx  = r_idx + 4'd1;
          w_next = S_LAUNCH;
        end
      end
      S_ROUND_END: begin
        if (r_hits >= 4'(PASS_HITS)) begin
          w_round   = (r_round == 8'hFF) ? r_round : r_round + 8'd1;
          w_hits    = 4'd0;
          w_idx     = 4'd0;
          w_dog_run = 1'b1;
          w_next    = S_INTRO;
        end else begin
          w_next = S_OVER;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_dog_run <= 1'b0;
      r_launch  <= 1'b0;
      r_shot    <= 1'b0;
      r_flyaway <= 1'b0;
      r_over    <= 1'b0;
      r_shots   <= 2'd0;
      r_idx     <= 4'd0;
      r_hits    <= 4'd0;
      r_score   <= 16'd0;
      r_round   <= 8'd0;
      r_timer   <= 10'd0;
    end else begin
      r_state   <= w_next;
      r_dog_run <= w_dog_run;
      r_launch  <= w_launch;
      r_shot    <= w_shot;
      r_flyaway <= (w_next == S_ESCAPE);
      r_over    <= (w_next == S_OVER);
      r_shots   <= w_shots;
      r_idx     <= w_idx;
      r_hits    <= w_hits;
      r_score   <= w_score;
      r_round   <= w_round;
      r_timer   <= w_timer;
    end
  end

  assign Dog_Run      = r_dog_run;
  assign Duck_Launch  = r_launch;
  assign Duck_Shot    = r_shot;
  assign Duck_FlyAway = r_flyaway;
  assign Game_Over    = r_over;
  assign Shots_Left   = r_shots;
  assign Duck_Index   = r_idx;
  assign Hits         = r_hits;
  assign Score        = r_score;
  assign Round        = r_round;
  assign State        = r_state;

endmodule

// File: tb/tb_duck_round_sequencer.sv
// Directed self-checking bench for duck_round_sequencer with hand-computed expectations.
module tb_duck_round_sequencer;

  logic        Clk = 1'b0, Reset = 1'b1;
  logic        Anim_Tick = 0, Start = 0, Dog_Done = 0, Trigger = 0, Hit = 0;
  logic        Duck_Offscreen = 0, Duck_Landed = 0;
  logic        Dog_Run, Duck_Launch, Duck_Shot, Duck_FlyAway, Game_Over;
  logic [1:0]  Shots_Left;
  logic [3:0]  Duck_Index, Hits, State;
  logic [15:0] Score;
  logic [7:0]  Round;

  int n_tests = 0, n_fail = 0;

  duck_round_sequencer dut (
    .Clk(Clk), .Reset(Reset), .Anim_Tick(Anim_Tick), .Start(Start), .Dog_Done(Dog_Done),
    .Trigger(Trigger), .Hit(Hit), .Duck_Offscreen(Duck_Offscreen), .Duck_Landed(Duck_Landed),
    .Dog_Run(Dog_Run), .Duck_Launch(Duck_Launch), .Duck_Shot(Duck_Shot),
    .Duck_FlyAway(Duck_FlyAway), .Game_Over(Game_Over), .Shots_Left(Shots_Left),
    .Duck_Index(Duck_Index), .Hits(Hits), .Score(Score), .Round(Round), .State(State)
  );

  always #5 Clk = ~Clk;

  task automatic step;
    @(posedge Clk); #1;
  endtask

  // One trigger rising edge (Trigger low for one edge first); returns just after the sampling edge.
  task automatic trig_edge(input logic hit);
    step;
    Trigger = 1'b1; Hit = hit;
    step;
    Trigger = 1'b0; Hit = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      Anim_Tick = 1'b1; step;
      Anim_Tick = 1'b0; step;
    end
  endtask

  // Starts in FLY; resolves one duck and ends in FLY of the next duck, or ROUND_END when last.
  task automatic play_duck(input logic hit, input logic last);
    if (hit) begin
      trig_edge(1'b1);
      Duck_Landed = 1'b1; step; Duck_Landed = 1'b0;
    end else begin
      repeat (3) trig_edge(1'b0);
      Duck_Offscreen = 1'b1; step; Duck_Offscreen = 1'b0;
    end
    step;
    if (!last) step;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge Clk);
    #1;
    n_tests++; if ({Dog_Run, Duck_Launch, Duck_Shot, Duck_FlyAway, Game_Over} !== 5'b0) begin n_fail++; $display("FAIL reset_pulses got %b exp 00000", {Dog_Run, Duck_Launch, Duck_Shot, Duck_FlyAway, Game_Over}); end
    n_tests++; if ({State, Shots_Left, Duck_Index, Hits, Score, Round} !== 38'd0) begin n_fail++; $display("FAIL reset_counters st=%0d sh=%0d idx=%0d hits=%0d score=%0d round=%0d exp all 0", State, Shots_Left, Duck_Index, Hits, Score, Round); end
    Reset = 1'b0;
    step;
    n_tests++; if (State !== 4'd0) begin n_fail++; $display("FAIL reset_idle got %0d exp 0", State); end
  endtask

  task automatic test_start;
    Start = 1'b1; step;
    n_tests++; if (Dog_Run !== 1'b1 || State !== 4'd1) begin n_fail++; $display("FAIL start_dogrun run=%b st=%0d exp 1/1", Dog_Run, State); end
    n_tests++; if (Round !== 8'd1) begin n_fail++; $display("FAIL start_round got %0d exp 1", Round); end
    Start = 1'b0; step;
    n_tests++; if (Dog_Run !== 1'b0) begin n_fail++; $display("FAIL start_pulse_width got %b exp 0", Dog_Run); end
    repeat (20) step;
    n_tests++; if (State !== 4'd1 || Duck_Launch !== 1'b0) begin n_fail++; $display("FAIL intro_wait st=%0d launch=%b exp 1/0", State, Duck_Launch); end
    Dog_Done = 1'b1; step; Dog_Done = 1'b0;
    n_tests++; if (State !== 4'd2 || Duck_Launch !== 1'b0) begin n_fail++; $display("FAIL launch_state st=%0d launch=%b exp 2/0", State, Duck_Launch); end
    step;
    n_tests++; if (Duck_Launch !== 1'b1 || State !== 4'd3 || Shots_Left !== 2'd3) begin n_fail++; $display("FAIL launch_pulse launch=%b st=%0d shots=%0d exp 1/3/3", Duck_Launch, State, Shots_Left); end
    step;
    n_tests++; if (Duck_Launch !== 1'b0) begin n_fail++; $display("FAIL launch_width got %b exp 0", Duck_Launch); end
  endtask

  task automatic test_miss_escape;
    logic [1:0] exp_sh [3] = '{2'd2, 2'd1, 2'd0};
    for (int i = 0; i < 3; i++) begin
      trig_edge(1'b0);
      n_tests++; if (Shots_Left !== exp_sh[i]) begin n_fail++; $display("FAIL miss_shots%0d got %0d exp %0d", i, Shots_Left, exp_sh[i]); end
    end
    n_tests++; if (State !== 4'd5 || Duck_FlyAway !== 1'b1) begin n_fail++; $display("FAIL miss_escape st=%0d fly=%b exp 5/1", State, Duck_FlyAway); end
    trig_edge(1'b1);
    repeat (3) step;
    n_tests++; if (Duck_FlyAway !== 1'b1 || Hits !== 4'd0 || Duck_Shot !== 1'b0) begin n_fail++; $display("FAIL escape_hold fly=%b hits=%0d exp 1/0", Duck_FlyAway, Hits); end
    Duck_Offscreen = 1'b1; step; Duck_Offscreen = 1'b0;
    n_tests++; if (State !== 4'd6 || Duck_FlyAway !== 1'b0) begin n_fail++; $display("FAIL escape_tally st=%0d fly=%b exp 6/0", State, Duck_FlyAway); end
    step;
    n_tests++; if (State !== 4'd2 || Duck_Index !== 4'd1) begin n_fail++; $display("FAIL tally_index st=%0d idx=%0d exp 2/1", State, Duck_Index); end
    step;
  endtask

  task automatic test_hit_on_timeout;
    ticks(479);
    Trigger = 1'b1; Hit = 1'b1; Anim_Tick = 1'b1;
    step;
    Trigger = 1'b0; Hit = 1'b0; Anim_Tick = 1'b0;
    n_tests++; if (State !== 4'd4 || Duck_Shot !== 1'b1) begin n_fail++; $display("FAIL hit_wins st=%0d shot=%b exp 4/1", State, Duck_Shot); end
    n_tests++; if (Hits !== 4'd1 || Score !== 16'd500 || Shots_Left !== 2'd2) begin n_fail++; $display("FAIL hit_counters hits=%0d score=%0d shots=%0d exp 1/500/2", Hits, Score, Shots_Left); end
    step;
    n_tests++; if (Duck_Shot !== 1'b0 || State !== 4'd4) begin n_fail++; $display("FAIL shot_width shot=%b st=%0d exp 0/4", Duck_Shot, State); end
    Duck_Landed = 1'b1; step; Duck_Landed = 1'b0;
    step; step;
    n_tests++; if (State !== 4'd3 || Duck_Index !== 4'd2) begin n_fail++; $display("FAIL fall_next st=%0d idx=%0d exp 3/2", State, Duck_Index); end
  endtask

  task automatic test_timeout;
    ticks(479);
    n_tests++; if (State !== 4'd3) begin n_fail++; $display("FAIL timeout_early got %0d exp 3", State); end
    Anim_Tick = 1'b1; step; Anim_Tick = 1'b0;
    n_tests++; if (State !== 4'd5 || Shots_Left !== 2'd3 || Duck_FlyAway !== 1'b1) begin n_fail++; $display("FAIL timeout_escape st=%0d shots=%0d fly=%b exp 5/3/1", State, Shots_Left, Duck_FlyAway); end
    Duck_Offscreen = 1'b1; step; Duck_Offscreen = 1'b0;
    step; step;
  endtask

  task automatic test_round_pass;
    for (int i = 3; i < 10; i++) play_duck(i < 8, i == 9);
    n_tests++; if (State !== 4'd7 || Hits !== 4'd6 || Score !== 16'd3000) begin n_fail++; $display("FAIL round_end st=%0d hits=%0d score=%0d exp 7/6/3000", State, Hits, Score); end
    step;
    n_tests++; if (State !== 4'd1 || Round !== 8'd2 || Hits !== 4'd0 || Dog_Run !== 1'b1 || Duck_Index !== 4'd0) begin n_fail++; $display("FAIL round_pass st=%0d round=%0d hits=%0d run=%b idx=%0d exp 1/2/0/1/0", State, Round, Hits, Dog_Run, Duck_Index); end
  endtask

  task automatic test_round_fail;
    Dog_Done = 1'b1; step; Dog_Done = 1'b0; step;
    for (int i = 0; i < 10; i++) play_duck(i < 5, i == 9);
    step;
    n_tests++; if (State !== 4'd8 || Game_Over !== 1'b1 || Hits !== 4'd5 || Round !== 8'd2 || Score !== 16'd5500) begin n_fail++; $display("FAIL over st=%0d go=%b hits=%0d round=%0d score=%0d exp 8/1/5/2/5500", State, Game_Over, Hits, Round, Score); end
    trig_edge(1'b1); step;
    n_tests++; if (Hits !== 4'd5 || Score !== 16'd5500 || State !== 4'd8) begin n_fail++; $display("FAIL over_hold hits=%0d score=%0d st=%0d exp 5/5500/8", Hits, Score, State); end
    Start = 1'b1; step; Start = 1'b0;
    n_tests++; if (State !== 4'd1 || Score !== 16'd0 || Round !== 8'd1 || Game_Over !== 1'b0 || Dog_Run !== 1'b1 || Hits !== 4'd0) begin n_fail++; $display("FAIL restart st=%0d score=%0d round=%0d go=%b run=%b hits=%0d exp 1/0/1/0/1/0", State, Score, Round, Game_Over, Dog_Run, Hits); end
  endtask

  task automatic test_reset_mid_fall;
    Dog_Done = 1'b1; step; Dog_Done = 1'b0; step;
    trig_edge(1'b1);
    n_tests++; if (State !== 4'd4) begin n_fail++; $display("FAIL pre_reset_fall got %0d exp 4", State); end
    Reset = 1'b1; #2;
    n_tests++; if ({State, Shots_Left, Duck_Index, Hits, Score, Round} !== 38'd0 || Duck_Shot !== 1'b0) begin n_fail++; $display("FAIL async_reset st=%0d sh=%0d idx=%0d hits=%0d score=%0d round=%0d exp all 0", State, Shots_Left, Duck_Index, Hits, Score, Round); end
    step; step;
    Reset = 1'b0;
    trig_edge(1'b1); trig_edge(1'b1); step;
    n_tests++; if (State !== 4'd0 || Score !== 16'd0 || Hits !== 4'd0 || Duck_Shot !== 1'b0 || Dog_Run !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle st=%0d score=%0d hits=%0d shot=%b run=%b exp 0/0/0/0/0", State, Score, Hits, Duck_Shot, Dog_Run); end
    Start = 1'b1; step; Start = 1'b0;
    n_tests++; if (Dog_Run !== 1'b1 || State !== 4'd1) begin n_fail++; $display("FAIL post_reset_start run=%b st=%0d exp 1/1", Dog_Run, State); end
  endtask

  initial begin
    test_reset;
    test_start;
    test_miss_escape;
    test_hit_on_timeout;
    test_timeout;
    test_round_pass;
    test_round_fail;
    test_reset_mid_fall;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
